// File: rtl/mem_port_arbiter_if.sv
// Requester and bus signal bundle for the unified memory port arbiter.
// The slave modport is the arbiter's view; master is the requesters plus memory.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  // Instruction fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_kill;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;

  // Data access requester
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_done;
  logic [DATA_W-1:0] mem_rdata;

  // Shared memory bus
  logic              bus_valid;
  logic              bus_ready;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [BE_W-1:0]   bus_be;
  logic              bus_rvalid;
  logic [DATA_W-1:0] bus_rdata;

  // Hazard unit stalls
  logic              stall_if;
  logic              stall_mem;

  modport slave (
    input  if_req, if_addr, if_kill,
    output if_done, if_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_done, mem_rdata,
    output bus_valid, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ready, bus_rvalid, bus_rdata,
    output stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, if_kill,
    input  if_done, if_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_done, mem_rdata,
    input  bus_valid, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ready, bus_rvalid, bus_rdata,
    input  stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one valid/ready + rvalid memory port between IF and MEM, one transaction at a time,
// with MEM priority bounded by a starvation counter and support for killing in-flight fetches.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave arb_io
);
  localparam int unsigned BE_W      = DATA_W / 8;
  localparam logic [3:0]  StarveMax = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StCmd, StResp} state_e;

  state_e            state_q;
  logic              owner_q;  // 1: MEM owns the bus
  logic              drop_q;
  logic [3:0]        starve_cnt_q;
  logic              bus_valid_q;
  logic              bus_we_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic [BE_W-1:0]   bus_be_q;

  logic if_want;
  logic if_forced;
  logic grant_mem;
  logic grant_if;
  logic kill_own;
  logic resp_done;
  logic if_done;
  logic mem_done;

  always_comb begin
    if_want   = arb_io.if_req & ~arb_io.if_kill;
    if_forced = if_want & (starve_cnt_q == StarveMax);
    grant_mem = (state_q == StIdle) & arb_io.mem_req & ~if_forced;
    grant_if  = (state_q == StIdle) & ~grant_mem & if_want;
    kill_own  = arb_io.if_kill & ~owner_q;
    resp_done = (state_q == StResp) & arb_io.bus_rvalid;
    mem_done  = resp_done & owner_q;
    if_done   = resp_done & ~owner_q & ~drop_q & ~arb_io.if_kill;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      drop_q       <= 1'b0;
      starve_cnt_q <= 4'd0;
      bus_valid_q  <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_be_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          drop_q <= 1'b0;
          if (grant_mem) begin
            state_q     <= StCmd;
            owner_q     <= 1'b1;
            bus_valid_q <= 1'b1;
            bus_we_q    <= arb_io.mem_we;
            bus_addr_q  <= arb_io.mem_addr;
            bus_wdata_q <= arb_io.mem_wdata;
            bus_be_q    <= arb_io.mem_be;
            // Only count grants that actually made IF wait
            if (arb_io.if_req && (starve_cnt_q < StarveMax)) begin
              starve_cnt_q <= starve_cnt_q + 4'd1;
            end
          end else if (grant_if) begin
            state_q      <= StCmd;
            owner_q      <= 1'b0;
            bus_valid_q  <= 1'b1;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= arb_io.if_addr;
            bus_be_q     <= '1;
            starve_cnt_q <= 4'd0;
          end
        end
        StCmd: begin
          // A killed fetch still has to be accepted and answered by the bus
          if (kill_own) drop_q <= 1'b1;
          if (arb_io.bus_ready) begin
            state_q     <= StResp;
            bus_valid_q <= 1'b0;
          end
        end
        StResp: begin
          if (kill_own) drop_q <= 1'b1;
          if (arb_io.bus_rvalid) begin
            state_q <= StIdle;
            drop_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign arb_io.bus_valid = bus_valid_q;
  assign arb_io.bus_we    = bus_we_q;
  assign arb_io.bus_addr  = bus_addr_q;
  assign arb_io.bus_wdata = bus_wdata_q;
  assign arb_io.bus_be    = bus_be_q;

  assign arb_io.if_done   = if_done;
  assign arb_io.mem_done  = mem_done;
  assign arb_io.if_rdata  = arb_io.bus_rdata;
  assign arb_io.mem_rdata = arb_io.bus_rdata;

  assign arb_io.stall_if  = arb_io.if_req & ~if_done;
  assign arb_io.stall_mem = arb_io.mem_req & ~mem_done;

  a_cmd_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (bus_valid_q && !arb_io.bus_ready) |=> (bus_valid_q && $stable(bus_addr_q) &&
      $stable(bus_wdata_q) && $stable(bus_be_q) && $stable(bus_we_q)));

  a_valid_in_cmd: assert property (@(posedge clk) disable iff (!rst_n)
    bus_valid_q == (state_q == StCmd));

  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
    starve_cnt_q <= StarveMax);

  a_one_done: assert property (@(posedge clk) disable iff (!rst_n)
    !(if_done && mem_done));

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between instruction fetch (IF) and data access (MEM stage) in the 5-stage pipeline.
- One transaction is outstanding at a time, using a valid/ready command handshake and an rvalid response.
- Produces per-requester stall signals that the hazard unit combines with its load-use and control-hazard logic.
- Supports killing an in-flight fetch on a taken branch or jump.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width. BE width is DATA_W/8.
- STARVE_LIMIT, 4, maximum consecutive MEM grants while IF is pending before IF is forced to win. Range 1..15.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request, held until if_done or if_kill.
- if_addr  in  ADDR_W  fetch address.
- if_kill  in  1  discard the current or in-flight fetch (pc_jump_enable).
- if_done  out  1  fetch complete this cycle.
- if_rdata  out  DATA_W  fetched instruction, valid with if_done.
- mem_req  in  1  data request, held until mem_done.
- mem_we  in  1  1 = write, 0 = read.
- mem_addr  in  ADDR_W  data address.
- mem_wdata  in  DATA_W  write data.
- mem_be  in  DATA_W/8  byte enables.
- mem_done  out  1  data access complete this cycle.
- mem_rdata  out  DATA_W  load data, valid with mem_done on reads.
- bus_valid  out  1  command valid.
- bus_ready  in  1  command accepted.
- bus_we  out  1  command write flag.
- bus_addr  out  ADDR_W  command address.
- bus_wdata  out  DATA_W  command write data.
- bus_be  out  DATA_W/8  command byte enables. All ones for fetches.
- bus_rvalid  in  1  response valid; this is read data or the write acknowledge.
- bus_rdata  in  DATA_W  response data.
- stall_if  out  1  IF must hold.
- stall_mem  out  1  MEM stage must hold.

Behaviour:
- FSM states: IDLE, CMD, RESP. Registers:
  - owner (0 = IF, 1 = MEM);
  - drop flag;
  - starve counter, 4 bits, saturating at STARVE_LIMIT;
  - command registers.
- Reset (async, rst_n = 0):
  - state IDLE, owner 0, drop 0, counter 0;
  - bus_valid 0, bus_we 0, bus_addr/bus_wdata/bus_be 0;
  - if_done 0, mem_done 0.
  - Reset asserted mid-transaction abandons it immediately and bus_valid drops asynchronously. The memory side must be reset together.
- IDLE grant decision:
  - MEM wins if mem_req, unless (if_req && !if_kill && counter == STARVE_LIMIT). In that case IF wins.
  - Otherwise IF wins if (if_req && !if_kill).
  - On a grant, latch the winner's command into the bus registers, set owner, and go to CMD.
  - A fetch latches bus_we = 0 and bus_be = all ones.
- Starve counter:
  - A MEM grant while if_req is high increments the counter, saturating.
  - An IF grant clears it.
  - Otherwise it holds.
- CMD: bus_valid = 1. Command fields are stable until bus_ready. On bus_valid && bus_ready, go to RESP. bus_valid is never retracted before acceptance, even on if_kill.
- RESP: bus_valid = 0. On bus_rvalid, complete and return to IDLE.
- Completion outputs are combinational in the bus_rvalid cycle:
  - mem_done = (RESP && owner == 1 && bus_rvalid).
  - if_done = (RESP && owner == 0 && bus_rvalid && !drop && !if_kill).
  - if_rdata and mem_rdata = bus_rdata.
- Requesters update or drop req on the clock edge that ends the done cycle. Next-request minimum latency is 1 IDLE cycle.
- Minimum transaction is 3 cycles: IDLE, CMD with bus_ready = 1, RESP with bus_rvalid = 1.
- if_kill:
  - if_kill while owner == 0 in CMD or RESP sets drop. That fetch completes on the bus silently, with no if_done.
  - drop clears on return to IDLE.
  - if_kill in IDLE blocks the IF grant that cycle.
  - if_kill in the completion cycle suppresses if_done.
- Stalls (combinational):
  - stall_if = if_req && !if_done.
  - stall_mem = mem_req && !mem_done.
  - With no requests, both are 0.
- Writes: bus_rvalid is the acknowledge. mem_rdata is don't-care when mem_we = 1.
- Unexpected bus_rvalid in IDLE or CMD is ignored.

Test Plan:
- Fetch only: if_req = 1, if_addr = 0x100, bus_ready = 1 at first CMD cycle, bus_rvalid the next cycle with rdata 0x00500093.
  - Required: bus_addr = 0x100, bus_be = 0xF, bus_we = 0.
  - if_done pulses once with if_rdata = 0x00500093 on the 3rd cycle.
  - stall_if is 1 for the first two cycles.
- Simultaneous requests: if_req and mem_req (read 0x2000) in the same IDLE cycle.
  - Required: MEM is granted first, bus_addr = 0x2000, stall_if stays 1.
  - IF is granted after mem_done. Counter reads 1, then 0.
- Starvation: mem_req held continuously (new address after each done) with if_req = 1.
  - Required: exactly 4 MEM grants, then an IF grant, then the counter returns to 0.
- Write with backpressure: mem_we = 1, addr 0x3000, wdata 0xDEADBEEF, be 0x3, bus_ready low for 3 cycles.
  - Required: bus_valid and all fields are stable for 4 cycles.
  - mem_done pulses on ack. No if activity.
- Kill in flight: IF fetch 0x104 accepted, if_kill pulsed in RESP, then bus_rvalid.
  - Required: no if_done, state returns to IDLE.
  - A new fetch at 0x200 is granted next and completes with if_done.
- Async reset mid-CMD: drop rst_n while bus_valid = 1.
  - Required: bus_valid = 0 immediately, and all done outputs and the counter are 0.
  - After release, the first request is granted normally.
